store_merge_unit: RTL
=====================

Name: store_merge_unit

Overview:
- Sequential successor to the store-size merger in the datapath.
- Performs word, halfword and byte stores as read-modify-write transactions against word-wide data memory.
- Any byte-lane position is supported; data width is parametrised.
- Sits between the control unit's store request and the memory port: takes register-B data plus byte address, fetches the containing word, merges the selected lanes, writes back, and reports done or an alignment error.

Parameters:
- DATA_W, 32, memory word width in bits; multiple of 8, >=16; LANES = DATA_W/8, OFS_W = log2(LANES).
- ADDR_W, 32, byte address width.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  store request; sampled only in IDLE.
- size  input  2  00 full word, 01 halfword, 10 byte, 11 reserved.
- addr  input  ADDR_W  byte address of the store.
- store_data  input  DATA_W  register-B value; low bits are the payload.
- busy  output  1  high from the cycle after accepted start until done/err is asserted.
- done  output  1  one-cycle pulse, store completed.
- err  output  1  one-cycle pulse, request rejected (misaligned or reserved size).
- mem_req  output  1  memory request, held until mem_ack.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  output  ADDR_W  word-aligned address (addr with low OFS_W bits cleared).
- mem_wdata  output  DATA_W  merged word; valid while mem_req and mem_we are high.
- mem_rdata  input  DATA_W  read data; valid in the mem_ack cycle of a read.
- mem_ack  input  1  memory completion; any latency >=1 cycle after mem_req rises.

Behaviour:
- Reset (synchronous, dominant in every state): state=IDLE; busy, done, err, mem_req, mem_we = 0; mem_addr, mem_wdata and the internal word register = 0.
- Reset mid-transaction aborts with no done/err pulse and drops mem_req on the next edge.
- FSM states: IDLE, READ, WRITE, FINISH, FAULT.
- IDLE, start=1:
  - Latch size, addr, store_data.
  - ofs = addr[OFS_W-1:0].
  - size=11, or size=01 with ofs[0]=1, or size=00 with ofs!=0: go to FAULT.
  - size=00 aligned: go to WRITE with mem_wdata=store_data; no read.
  - Otherwise: go to READ with mem_req=1, mem_we=0.
- READ: hold mem_req, mem_addr. On mem_ack:
  - Merge, little-endian lanes: byte replaces lane ofs with store_data[7:0]; half replaces lanes ofs and ofs+1 with store_data[15:0]; all other lanes come from mem_rdata.
  - Register the merged word into mem_wdata; next cycle is WRITE with mem_we=1.
- WRITE: mem_req=1, mem_we=1. On mem_ack, drop mem_req/mem_we and go to FINISH.
- FINISH: done=1 for one cycle, then IDLE.
- FAULT: err=1 for one cycle with no memory access, then IDLE.
- busy=1 in READ, WRITE, FINISH and FAULT.
- start while busy is ignored; no queueing.
- A new start is accepted only in IDLE, so back-to-back stores have at least one idle cycle between done and the next accept.
- Latency (ack latency 1): aligned word store = accept + WRITE + FINISH = done 3 cycles after start. Sub-word store = done 5 cycles after start.
- mem_ack outside READ/WRITE is ignored.
- mem_addr and mem_wdata stay stable for the whole request; they hold their last value when idle.

Decomposition:
- Shared package holds:
  - Size encoding constants SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10, SZ_RSVD=2'b11 (shared with the load-size unit).
  - State encoding.
- One combinational sub-module, store_lane_merge (parameters DATA_W): inputs old word, store_data, size, ofs; output merged word. This is reused by a future write-buffer.

Test Plan:
- Byte, DATA_W=32: mem word 0xAABBCCDD at 0x100; store_data=0x12345678, size=10, addr=0x102 -> read of 0x100, then write 0xAA78CCDD; done 5 cycles after start.
- Halfword: same memory word, size=01, addr=0x102, store_data=0x0000BEEF -> write 0xBEEFCCDD; lanes 0-1 unchanged.
- Word: size=00, addr=0x104, store_data=0xDEADBEEF -> single write of 0xDEADBEEF to 0x104, no read request; done 3 cycles after start (ack latency 1).
- Faults: size=01 addr=0x103; size=00 addr=0x101; size=11 -> err pulse 1 cycle, mem_req never rises, busy for 1 cycle.
- Slow memory with mem_ack after 4 cycles, plus start pulsed during busy -> mem_req/mem_addr held stable until ack, the second start is ignored, and exactly one done pulse occurs.
- Reset asserted during READ -> next edge: mem_req=0, busy=0, state IDLE, no done; a subsequent byte store completes normally.

Source files
------------

// File: rtl/store_merge_unit_pkg.sv
// Shared encodings for the store/load size units and the store-merge FSM.
package store_merge_unit_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_FINISH = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    // A request is rejected when the size is reserved or the offset breaks natural alignment.
    function automatic logic req_fault(input logic [1:0] size, input logic ofs_lsb, input logic ofs_nz);
        case (size)
            SZ_WORD: req_fault = ofs_nz;
            SZ_HALF: req_fault = ofs_lsb;
            SZ_BYTE: req_fault = 1'b0;
            default: req_fault = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/store_merge_unit_lane_merge.sv
// Combinational little-endian lane merge of a store payload into an existing word.
module store_lane_merge
    import store_merge_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANES  = DATA_W / 8,
    parameter int OFS_W  = $clog2(LANES)
) (
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] store_data,
    input  logic [1:0]        size,
    input  logic [OFS_W-1:0]  ofs,
    output logic [DATA_W-1:0] merged
);

    // Halfwords are even-aligned, so the upper lane is ofs with its lsb set.
    logic [OFS_W-1:0] ofs_hi_s;
    assign ofs_hi_s = ofs | OFS_W'(1);

    // Select each lane from the payload or from the old word.
    always_comb begin
        merged = old_word;
        for (int i = 0; i < LANES; i++) begin
            case (size)
                SZ_WORD: merged[i*8 +: 8] = store_data[i*8 +: 8];
                SZ_HALF: begin
                    if (ofs == OFS_W'(i)) begin
                        merged[i*8 +: 8] = store_data[7:0];
                    end else if (ofs_hi_s == OFS_W'(i)) begin
                        merged[i*8 +: 8] = store_data[15:8];
                    end else begin
                        merged[i*8 +: 8] = old_word[i*8 +: 8];
                    end
                end
                SZ_BYTE: begin
                    if (ofs == OFS_W'(i)) begin
                        merged[i*8 +: 8] = store_data[7:0];
                    end else begin
                        merged[i*8 +: 8] = old_word[i*8 +: 8];
                    end
                end
                default: merged[i*8 +: 8] = old_word[i*8 +: 8];
            endcase
        end
    end

endmodule

// File: rtl/store_merge_unit.sv
// Read-modify-write store engine: fetches the containing word, merges lanes, writes back.
module store_merge_unit
    import store_merge_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int LANES = DATA_W / 8;
    localparam int OFS_W = $clog2(LANES);

    state_t            state_r, state_s;
    logic [1:0]        size_r, size_s;
    logic [OFS_W-1:0]  ofs_r, ofs_s;
    logic [DATA_W-1:0] data_r, data_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
    logic              busy_r, done_r, err_r, mem_req_r, mem_we_r;
    logic [DATA_W-1:0] merged_s;
    logic [OFS_W-1:0]  addr_ofs_s;

    assign addr_ofs_s = addr[OFS_W-1:0];

    store_lane_merge #(.DATA_W(DATA_W)) u_merge (
        .old_word   (mem_rdata),
        .store_data (data_r),
        .size       (size_r),
        .ofs        (ofs_r),
        .merged     (merged_s)
    );

    // Next-state and next-datapath logic.
    always_comb begin
        state_s     = state_r;
        size_s      = size_r;
        ofs_s       = ofs_r;
        data_s      = data_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    size_s = size;
                    ofs_s  = addr_ofs_s;
                    data_s = store_data;
                    if (req_fault(size, addr_ofs_s[0], addr_ofs_s != '0)) begin
                        state_s = ST_FAULT;
                    end else if (size == SZ_WORD) begin
                        state_s     = ST_WRITE;
                        mem_addr_s  = addr & ~(ADDR_W'(LANES - 1));
                        mem_wdata_s = store_data;
                    end else begin
                        state_s    = ST_READ;
                        mem_addr_s = addr & ~(ADDR_W'(LANES - 1));
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (mem_ack) begin
                    state_s     = ST_WRITE;
                    mem_wdata_s = merged_s;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    state_s = ST_FINISH;
                end else begin
                    state_s = ST_WRITE;
                end
            end
            ST_FINISH: state_s = ST_IDLE;
            ST_FAULT:  state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // State, datapath and registered handshake outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            size_r      <= 2'b00;
            ofs_r       <= '0;
            data_r      <= '0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            size_r      <= size_s;
            ofs_r       <= ofs_s;
            data_r      <= data_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            busy_r      <= (state_s != ST_IDLE);
            done_r      <= (state_s == ST_FINISH);
            err_r       <= (state_s == ST_FAULT);
            mem_req_r   <= (state_s == ST_READ) || (state_s == ST_WRITE);
            mem_we_r    <= (state_s == ST_WRITE);
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule
